// File: rtl/seq_controller.sv
// rtl/seq_controller.sv - instruction decode and sequencing controller
//
// Purpose: decodes one instruction per cycle into a registered control bundle.
// Loads and stores hold the pipeline in MEM until the data memory acks or times out.
// WFI parks the core until an enabled interrupt line wakes it.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   inst_valid                 opcode/funct3/funct7 carry an instruction this cycle
//   opcode, funct3, funct7     instruction fields
//   dmem_ack                   data memory completes the outstanding access
//   irq, irq_mask              wake requests and per-line enables
//   reg_w_en .. csr_w_en, ret  registered control bundle
//   ctrl_valid, stall,         registered status
//   dmem_req, illegal,
//   bus_err, wake, state       (state: 00 RUN, 01 MEM, 10 WFI)
module seq_controller #(
  parameter int unsigned NUM_IRQ    = 4,
  parameter int unsigned TIMEOUT_W  = 8,
  parameter int unsigned ENABLE_WFI = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inst_valid,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic               dmem_ack,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_mask,
  output logic               reg_w_en,
  output logic               dmem_w_en,
  output logic               store_load_sel,
  output logic [1:0]         reg_w_sel,
  output logic               rs2_imm_sel,
  output logic [1:0]         imm_sel,
  output logic               rs1_pc_sel,
  output logic               jump_en,
  output logic               branch_en,
  output logic               csr_w_en,
  output logic               ret,
  output logic               ctrl_valid,
  output logic               stall,
  output logic               dmem_req,
  output logic               illegal,
  output logic               bus_err,
  output logic               wake,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    S_RUN = 2'b00,
    S_MEM = 2'b01,
    S_WFI = 2'b10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] F7_MRET   = 7'b0011000;
  localparam logic [6:0] F7_WFI    = 7'b0001000;

  // Bundle bit order: reg_w_en, dmem_w_en, store_load_sel, reg_w_sel[1:0],
  // rs2_imm_sel, imm_sel[1:0], rs1_pc_sel, jump_en, branch_en, csr_w_en
  localparam logic [11:0] B_LOAD   = 12'b1_0_1_00_1_01_0_0_0_0;
  localparam logic [11:0] B_STORE  = 12'b0_1_0_00_1_01_0_0_0_0;
  localparam logic [11:0] B_OP     = 12'b1_0_0_01_0_01_0_0_0_0;
  localparam logic [11:0] B_OPIMM  = 12'b1_0_0_01_1_01_0_0_0_0;
  localparam logic [11:0] B_BRANCH = 12'b0_0_0_00_0_01_0_0_1_0;
  localparam logic [11:0] B_LUI    = 12'b1_0_0_01_1_00_0_0_0_0;
  localparam logic [11:0] B_AUIPC  = 12'b1_0_0_01_1_00_1_0_0_0;
  localparam logic [11:0] B_JAL    = 12'b1_0_0_10_1_10_1_1_0_0;
  localparam logic [11:0] B_JALR   = 12'b1_0_0_10_1_01_0_1_0_0;
  localparam logic [11:0] B_CSR    = 12'b1_0_0_11_0_11_0_0_0_1;
  localparam logic [11:0] B_JUMP   = 12'b0_0_0_00_0_00_0_1_0_0;
  localparam logic [11:0] B_REGW   = 12'b1_0_0_00_0_00_0_0_0_0;

  // The edge that sees this count with no ack is the (2^W-1)-th unanswered MEM cycle.
  localparam logic [TIMEOUT_W-1:0] CNT_TERM = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  localparam logic [TIMEOUT_W-1:0] CNT_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [11:0]          bundle_q, bundle_d;
  logic                 ret_d, ctrl_valid_d, stall_d, dmem_req_d;
  logic                 illegal_d, bus_err_d, wake_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      cnt_q      <= '0;
      bundle_q   <= '0;
      ret        <= 1'b0;
      ctrl_valid <= 1'b0;
      stall      <= 1'b0;
      dmem_req   <= 1'b0;
      illegal    <= 1'b0;
      bus_err    <= 1'b0;
      wake       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bundle_q   <= bundle_d;
      ret        <= ret_d;
      ctrl_valid <= ctrl_valid_d;
      stall      <= stall_d;
      dmem_req   <= dmem_req_d;
      illegal    <= illegal_d;
      bus_err    <= bus_err_d;
      wake       <= wake_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bundle_d     = '0;
    ret_d        = 1'b0;
    ctrl_valid_d = 1'b0;
    stall_d      = 1'b0;
    dmem_req_d   = 1'b0;
    illegal_d    = 1'b0;
    bus_err_d    = 1'b0;
    wake_d       = 1'b0;
    case (state_q)
      S_RUN: begin
        if (inst_valid) begin
          ctrl_valid_d = 1'b1;
          case (opcode)
            OP_LOAD, OP_STORE: begin
              // A load's register write waits for the data to return.
              bundle_d   = (opcode == OP_LOAD) ? (B_LOAD & ~B_REGW) : B_STORE;
              state_d    = S_MEM;
              cnt_d      = '0;
              stall_d    = 1'b1;
              dmem_req_d = 1'b1;
            end
            OP_OP:     bundle_d = B_OP;
            OP_OPIMM:  bundle_d = B_OPIMM;
            OP_BRANCH: bundle_d = B_BRANCH;
            OP_LUI:    bundle_d = B_LUI;
            OP_AUIPC:  bundle_d = B_AUIPC;
            OP_JAL:    bundle_d = B_JAL;
            OP_JALR:   bundle_d = B_JALR;
            OP_SYSTEM: begin
              if (funct3 != 3'b000) begin
                bundle_d = B_CSR;
              end else if (funct7 == F7_MRET) begin
                bundle_d = B_JUMP;
                ret_d    = 1'b1;
              end else if (funct7 == F7_WFI) begin
                // With WFI disabled it retires as a NOP.
                if (ENABLE_WFI != 0) begin
                  state_d      = S_WFI;
                  stall_d      = 1'b1;
                  ctrl_valid_d = 1'b0;
                end
              end else begin
                illegal_d = 1'b1;
              end
            end
            default: illegal_d = 1'b1;
          endcase
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          // Ack beats a coincident timeout; only a load produces a write-back cycle.
          state_d = S_RUN;
          if (bundle_q[9]) begin
            bundle_d     = bundle_q | B_REGW;
            ctrl_valid_d = 1'b1;
          end
        end else if (cnt_q == CNT_TERM) begin
          state_d   = S_RUN;
          bus_err_d = 1'b1;
        end else begin
          cnt_d        = cnt_q + CNT_ONE;
          bundle_d     = bundle_q;
          ctrl_valid_d = 1'b1;
          stall_d      = 1'b1;
          dmem_req_d   = 1'b1;
        end
      end
      S_WFI: begin
        // Entry is registered from RUN, so an irq already pending still costs one WFI cycle.
        if (|(irq & irq_mask)) begin
          state_d = S_RUN;
          wake_d  = 1'b1;
        end else begin
          stall_d = 1'b1;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  assign {reg_w_en, dmem_w_en, store_load_sel, reg_w_sel, rs2_imm_sel,
          imm_sel, rs1_pc_sel, jump_en, branch_en, csr_w_en} = bundle_q;
  assign state = state_q;

endmodule

// File: tb/tb_seq_controller.sv
// tb/tb_seq_controller.sv - scoreboard bench for seq_controller
module tb_seq_controller;

  localparam int NUM_IRQ = 4;
  localparam int TW      = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               inst_valid = 1'b0;
  logic [6:0]         opcode = '0;
  logic [2:0]         funct3 = '0;
  logic [6:0]         funct7 = '0;
  logic               dmem_ack = 1'b0;
  logic [NUM_IRQ-1:0] irq = '0;
  logic [NUM_IRQ-1:0] irq_mask = '0;
  logic               reg_w_en, dmem_w_en, store_load_sel, rs2_imm_sel, rs1_pc_sel;
  logic               jump_en, branch_en, csr_w_en, ret, ctrl_valid, stall, dmem_req;
  logic               illegal, bus_err, wake;
  logic [1:0]         reg_w_sel, imm_sel, state;

  seq_controller #(.NUM_IRQ(NUM_IRQ), .TIMEOUT_W(TW), .ENABLE_WFI(1)) dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .dmem_ack(dmem_ack), .irq(irq), .irq_mask(irq_mask),
    .reg_w_en(reg_w_en), .dmem_w_en(dmem_w_en), .store_load_sel(store_load_sel),
    .reg_w_sel(reg_w_sel), .rs2_imm_sel(rs2_imm_sel), .imm_sel(imm_sel),
    .rs1_pc_sel(rs1_pc_sel), .jump_en(jump_en), .branch_en(branch_en),
    .csr_w_en(csr_w_en), .ret(ret), .ctrl_valid(ctrl_valid), .stall(stall),
    .dmem_req(dmem_req), .illegal(illegal), .bus_err(bus_err), .wake(wake),
    .state(state)
  );

  always #5 clk = ~clk;

  // bundle: reg_w_en dmem_w_en store_load_sel reg_w_sel rs2_imm_sel imm_sel rs1_pc_sel jump_en branch_en csr_w_en
  typedef struct packed {
    logic [11:0] bundle;
    logic        ret;
    logic        ctrl_valid;
    logic        stall;
    logic        dmem_req;
    logic        illegal;
    logic        bus_err;
    logic        wake;
    logic [1:0]  state;
  } out_t;

  localparam logic [6:0] SYS = 7'b1110011;

  out_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;

  // Monitor: one expected entry per output cycle, pushed by the driver before the edge.
  initial begin
    out_t e, g;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {reg_w_en, dmem_w_en, store_load_sel, reg_w_sel, rs2_imm_sel, imm_sel,
             rs1_pc_sel, jump_en, branch_en, csr_w_en, ret, ctrl_valid, stall,
             dmem_req, illegal, bus_err, wake, state};
        checks++;
        if (g !== e) begin
          failures++;
          $display("FAIL outputs cycle=%0d got=%b_%b_%b exp=%b_%b_%b", cycle,
                   g.bundle, g[8:2], g.state, e.bundle, e[8:2], e.state);
        end
      end
    end
  end

  task automatic check_now(input out_t e, input string tag);
    out_t g;
    g = {reg_w_en, dmem_w_en, store_load_sel, reg_w_sel, rs2_imm_sel, imm_sel,
         rs1_pc_sel, jump_en, branch_en, csr_w_en, ret, ctrl_valid, stall,
         dmem_req, illegal, bus_err, wake, state};
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s got=%b_%b_%b exp=%b_%b_%b", tag,
               g.bundle, g[8:2], g.state, e.bundle, e[8:2], e.state);
    end
  endtask

  // Reference decode: cls 0 single-cycle, 1 load, 2 store, 3 wfi.
  function automatic out_t model(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, output int cls);
    out_t o;
    o = '0;
    o.ctrl_valid = 1'b1;
    cls = 0;
    case (op)
      7'b0000011: begin o.bundle = 12'b0_0_1_00_1_01_0_0_0_0; cls = 1; end
      7'b0100011: begin o.bundle = 12'b0_1_0_00_1_01_0_0_0_0; cls = 2; end
      7'b0110011: o.bundle = 12'b1_0_0_01_0_01_0_0_0_0;
      7'b0010011: o.bundle = 12'b1_0_0_01_1_01_0_0_0_0;
      7'b1100011: o.bundle = 12'b0_0_0_00_0_01_0_0_1_0;
      7'b0110111: o.bundle = 12'b1_0_0_01_1_00_0_0_0_0;
      7'b0010111: o.bundle = 12'b1_0_0_01_1_00_1_0_0_0;
      7'b1101111: o.bundle = 12'b1_0_0_10_1_10_1_1_0_0;
      7'b1100111: o.bundle = 12'b1_0_0_10_1_01_0_1_0_0;
      SYS: begin
        if (f3 != 3'b000) o.bundle = 12'b1_0_0_11_0_11_0_0_0_1;
        else if (f7 == 7'b0011000) begin o.ret = 1'b1; o.bundle = 12'h004; end
        else if (f7 == 7'b0001000) cls = 3;
        else o.illegal = 1'b1;
      end
      default: o.illegal = 1'b1;
    endcase
    if (cls == 1 || cls == 2) begin o.stall = 1'b1; o.dmem_req = 1'b1; o.state = 2'b01; end
    if (cls == 3) begin o.ctrl_valid = 1'b0; o.stall = 1'b1; o.state = 2'b10; end
    return o;
  endfunction

  task automatic cyc(input bit r, input bit iv, input logic [6:0] op, input logic [2:0] f3,
                     input logic [6:0] f7, input bit ack, input logic [3:0] ir,
                     input logic [3:0] im, input out_t e);
    @(negedge clk);
    rst = r; inst_valid = iv; opcode = op; funct3 = f3; funct7 = f7;
    dmem_ack = ack; irq = ir; irq_mask = im;
    exp_q.push_back(e);
  endtask

  // Cycle with random (ignored) instruction fields.
  task automatic gcyc(input bit r, input bit ack, input logic [3:0] ir, input logic [3:0] im,
                      input out_t e);
    cyc(r, 1'($urandom), 7'($urandom), 3'($urandom), 7'($urandom), ack, ir, im, e);
  endtask

  // k: cycle of ack (4 = never, times out); waits: WFI cycles before wake; rst_at: reset cycle.
  task automatic do_inst(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input int k, input int waits, input int rst_at);
    out_t e, d;
    int cls;
    logic [3:0] ir, im;
    e = model(op, f3, f7, cls);
    cyc(0, 1, op, f3, f7, 1'($urandom), 4'($urandom), 4'($urandom), e);
    if (cls == 1 || cls == 2) begin
      for (int i = 1; i <= 3; i++) begin
        if (i == rst_at) begin gcyc(1, 0, 4'($urandom), 4'($urandom), '0); return; end
        if (i == k) begin
          d = '0;
          if (cls == 1) begin
            d = e; d.bundle[11] = 1'b1; d.stall = 0; d.dmem_req = 0; d.state = 2'b00;
          end
          gcyc(0, 1, 4'($urandom), 4'($urandom), d);
          return;
        end
        if (i == 3) begin
          d = '0; d.bus_err = 1'b1;
          gcyc(0, 0, 4'($urandom), 4'($urandom), d);
          return;
        end
        gcyc(0, 0, 4'($urandom), 4'($urandom), e);
      end
    end else if (cls == 3) begin
      for (int i = 1; i <= waits; i++) begin
        ir = 4'($urandom);
        im = 4'($urandom) & ~ir;
        if (i == rst_at) begin gcyc(1, 1'($urandom), ir, im, '0); return; end
        gcyc(0, 1'($urandom), ir, im, e);
      end
      ir = 4'($urandom_range(1, 15));
      im = ir | 4'($urandom);
      d = '0; d.wake = 1'b1;
      gcyc(0, 1'($urandom), ir, im, d);
    end
  endtask

  initial begin
    out_t e, d, t;
    int cls, sel;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [6:0] ops [10];
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, SYS};

    // Reset dominates a valid instruction.
    cyc(1, 1, 7'b0010011, 0, 0, 1, 4'hf, 4'hf, '0);
    cyc(1, 1, 7'b0000011, 0, 0, 0, 0, 0, '0);
    @(posedge clk);
    #2;
    check_now('0, "reset_state");
    // OP-IMM straight out of reset.
    do_inst(7'b0010011, 3'b000, 7'd0, 0, 0, 0);
    // Load acked on the third MEM cycle.
    do_inst(7'b0000011, 3'b010, 7'd0, 3, 0, 0);
    // Store timeout, then store acked on the terminal cycle.
    do_inst(7'b0100011, 3'b010, 7'd0, 4, 0, 0);
    @(posedge clk);
    #2;
    t = '0; t.bus_err = 1'b1;
    check_now(t, "timeout_expired");
    do_inst(7'b0100011, 3'b010, 7'd0, 3, 0, 0);
    // WFI: irq=0010 with mask 0001 holds, mask 0011 wakes.
    e = model(SYS, 3'b000, 7'b0001000, cls);
    cyc(0, 1, SYS, 3'b000, 7'b0001000, 0, 4'b0010, 4'b0001, e);
    cyc(0, 0, 0, 0, 0, 1, 4'b0010, 4'b0001, e);
    cyc(0, 0, 0, 0, 0, 0, 4'b0010, 4'b0001, e);
    d = '0; d.wake = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 4'b0010, 4'b0011, d);
    // mret followed by an undefined opcode.
    do_inst(SYS, 3'b000, 7'b0011000, 0, 0, 0);
    do_inst(7'b1111111, 3'b000, 7'd0, 0, 0, 0);
    // Reset mid-MEM, then a stray ack in RUN.
    do_inst(7'b0000011, 3'b010, 7'd0, 4, 0, 2);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, '0);
    // Reset mid-WFI.
    do_inst(SYS, 3'b000, 7'b0001000, 0, 3, 2);
    // Pending irq at WFI entry still costs one WFI cycle.
    e = model(SYS, 3'b000, 7'b0001000, cls);
    cyc(0, 1, SYS, 3'b000, 7'b0001000, 0, 4'b0100, 4'b0100, e);
    cyc(0, 0, 0, 0, 0, 0, 4'b0100, 4'b0100, d);

    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 15);
      if (sel < 2) begin
        cyc(0, 0, 7'($urandom), 3'($urandom), 7'($urandom), 1'($urandom),
            4'($urandom), 4'($urandom), '0);
      end else begin
        op = (sel == 2) ? 7'($urandom) : ops[$urandom_range(0, 9)];
        f3 = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom);
        case ($urandom_range(0, 2))
          0:       f7 = 7'b0011000;
          1:       f7 = 7'b0001000;
          default: f7 = 7'($urandom);
        endcase
        do_inst(op, f3, f7, $urandom_range(1, 4), $urandom_range(0, 3),
                ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
      end
    end

    cyc(0, 0, 0, 0, 0, 0, 0, 0, '0);
    @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
